lcv_div_iter: RTL and testbench

- Iterative radix-2 restoring integer divider, signed or unsigned. It is the inverse companion to the LcvMulAcc multiply/accumulate blocks.
- It is the long-latency divide unit beside the single-cycle ALU.
- Operands enter through a valid/ready handshake, and the block computes one quotient bit per cycle.
- Quotient and remainder are returned through a second valid/ready handshake.

---
 rtl/lcv_div_pkg.sv | 31 +++
 rtl/lcv_div_iter_step.sv | 24 ++
 rtl/lcv_div_iter.sv | 133 +++++++++++++
 tb/tb_lcv_div_iter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcv_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Width-dependent constants are built at MAX_WIDTH and truncated by the user.
package lcv_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int MAX_WIDTH = 128;

  function automatic logic [MAX_WIDTH-1:0] most_neg(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

  // Quotient reported on divide by zero: all ones at width w.
  function automatic logic [MAX_WIDTH-1:0] div_zero_quot(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcv_div_iter_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, then
// subtract the divisor if it fits.
module lcv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] dvs_ext;
  logic           ge;

  assign rem_shift = {rem_in[WIDTH-1:0], dividend_bit};
  assign dvs_ext   = {1'b0, divisor};
  // A set top bit would be shifted out, so the true value already exceeds the divisor.
  assign ge        = rem_in[WIDTH] || (rem_shift >= dvs_ext);
  assign rem_out   = ge ? (rem_shift - dvs_ext) : rem_shift;
  assign quot_bit  = ge;

endmodule

// File: rtl/lcv_div_iter.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit per
// cycle, with valid/ready handshakes on both the request and the result side.
//
// state | meaning
// IDLE  | waiting for a request, inp_ready=1
// BUSY  | one restoring step per cycle, counter WIDTH-1 down to 0
// FIX   | sign correction, result registers loaded
// DONE  | outp_valid=1 until outp_ready
module lcv_div_iter
  import lcv_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             inp_signed,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp_quot,
  output logic [WIDTH-1:0] outp_rem,
  output logic             outp_div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
  localparam logic [WIDTH-1:0] QUOT_DZ  = WIDTH'(div_zero_quot(WIDTH));
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dq_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg, r_neg;

  logic             is_dz, is_ovf, cnt_tc;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  assign is_dz  = (inp_b == '0);
  assign is_ovf = inp_signed && (inp_a == MOST_NEG) && (inp_b == '1);
  assign a_mag  = (inp_signed && inp_a[WIDTH-1]) ? -inp_a : inp_a;
  assign b_mag  = (inp_signed && inp_b[WIDTH-1]) ? -inp_b : inp_b;
  assign cnt_tc = (cnt == '0);

  // dq_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
  lcv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem_q),
    .divisor     (dvs_q),
    .dividend_bit(dq_q[WIDTH-1]),
    .rem_out     (step_rem),
    .quot_bit    (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    inp_ready  = 1'b0;
    outp_valid = 1'b0;
    case (state)
      IDLE: begin
        inp_ready = 1'b1;
        if (inp_valid) state_nxt = (is_dz || is_ovf) ? DONE : BUSY;
      end
      BUSY: if (cnt_tc) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        outp_valid = 1'b1;
        if (outp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      rem_q         <= '0;
      dq_q          <= '0;
      dvs_q         <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      outp_quot     <= '0;
      outp_rem      <= '0;
      outp_div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inp_valid) begin
            if (is_dz) begin
              outp_quot     <= QUOT_DZ;
              outp_rem      <= inp_a;
              outp_div_zero <= 1'b1;
            end else if (is_ovf) begin
              outp_quot     <= inp_a;
              outp_rem      <= '0;
              outp_div_zero <= 1'b0;
            end else begin
              rem_q <= '0;
              dq_q  <= a_mag;
              dvs_q <= b_mag;
              q_neg <= inp_signed && (inp_a[WIDTH-1] ^ inp_b[WIDTH-1]);
              r_neg <= inp_signed && inp_a[WIDTH-1];
              cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          rem_q <= step_rem;
          dq_q  <= {dq_q[WIDTH-2:0], step_qbit};
          if (!cnt_tc) cnt <= cnt - 1'b1;
        end
        FIX: begin
          outp_quot     <= q_neg ? -dq_q : dq_q;
          outp_rem      <= r_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          outp_div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcv_div_iter.sv
// Self-checking bench for lcv_div_iter at WIDTH=32: directed cases plus a long
// randomized back-to-back run against a plain-arithmetic reference model.
module tb_lcv_div_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         inp_valid;
  logic         inp_ready;
  logic [W-1:0] inp_a, inp_b;
  logic         inp_signed;
  logic         outp_valid;
  logic         outp_ready;
  logic [W-1:0] outp_quot, outp_rem;
  logic         outp_div_zero;

  int tests = 0;
  int fails = 0;

  lcv_div_iter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .inp_valid    (inp_valid),
    .inp_ready    (inp_ready),
    .inp_a        (inp_a),
    .inp_b        (inp_b),
    .inp_signed   (inp_signed),
    .outp_valid   (outp_valid),
    .outp_ready   (outp_ready),
    .outp_quot    (outp_quot),
    .outp_rem     (outp_rem),
    .outp_div_zero(outp_div_zero)
  );

  always #5 clk = ~clk;

  // Reference: truncating division via 64-bit signed/unsigned arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Drives one request; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    @(negedge clk);
    while (!inp_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!inp_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout inp_ready=%0b required 1", inp_ready);
    end
    inp_a = a; inp_b = b; inp_signed = s; inp_valid = 1'b1;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    inp_a = $urandom; inp_b = $urandom; inp_signed = 1'($urandom_range(0, 1));
  endtask

  // Latency counted in edges from the accept edge (accept edge = 1).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!outp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!outp_valid) begin
      tests++; fails++;
      $display("FAIL valid_timeout outp_valid=%0b required 1", outp_valid);
    end
  endtask

  task automatic consume();
    outp_ready = 1'b1;
    @(posedge clk); #1;
    outp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++; if (inp_ready !== 1'b1) begin fails++; $display("FAIL reset_inp_ready got %0b want 1", inp_ready); end
    tests++; if (outp_valid !== 1'b0) begin fails++; $display("FAIL reset_outp_valid got %0b want 0", outp_valid); end
    tests++; if (outp_quot !== '0) begin fails++; $display("FAIL reset_quot got %h want 0", outp_quot); end
    tests++; if (outp_rem !== '0) begin fails++; $display("FAIL reset_rem got %h want 0", outp_rem); end
    tests++; if (outp_div_zero !== 1'b0) begin fails++; $display("FAIL reset_div_zero got %0b want 0", outp_div_zero); end
  endtask

  task automatic test_basic();
    int lat;
    issue(32'd100, 32'd7, 1'b0);
    wait_valid(lat);
    tests++; if (lat != 34) begin fails++; $display("FAIL u100_7_latency got %0d want 34", lat); end
    tests++; if (outp_quot !== 32'd14) begin fails++; $display("FAIL u100_7_quot got %0d want 14", outp_quot); end
    tests++; if (outp_rem !== 32'd2) begin fails++; $display("FAIL u100_7_rem got %0d want 2", outp_rem); end
    tests++; if (outp_div_zero !== 1'b0) begin fails++; $display("FAIL u100_7_dz got %0b want 0", outp_div_zero); end
    consume();
    issue(-32'sd7, 32'd2, 1'b1);
    wait_valid(lat);
    tests++; if (outp_quot !== 32'hFFFF_FFFD) begin fails++; $display("FAIL s_m7_2_quot got %h want fffffffd", outp_quot); end
    tests++; if (outp_rem !== 32'hFFFF_FFFF) begin fails++; $display("FAIL s_m7_2_rem got %h want ffffffff", outp_rem); end
    consume();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_valid(lat);
    tests++; if (outp_quot !== 32'hFFFF_FFFF) begin fails++; $display("FAIL u_max_1_quot got %h want ffffffff", outp_quot); end
    tests++; if (outp_rem !== 32'd0) begin fails++; $display("FAIL u_max_1_rem got %h want 0", outp_rem); end
    consume();
  endtask

  task automatic test_special();
    int lat;
    for (int s = 0; s < 2; s++) begin
      issue(32'd5, 32'd0, 1'(s));
      wait_valid(lat);
      tests++; if (lat != 1) begin fails++; $display("FAIL dz_latency mode=%0d got %0d want 1", s, lat); end
      tests++; if (outp_quot !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dz_quot mode=%0d got %h want ffffffff", s, outp_quot); end
      tests++; if (outp_rem !== 32'd5) begin fails++; $display("FAIL dz_rem mode=%0d got %h want 5", s, outp_rem); end
      tests++; if (outp_div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag mode=%0d got %0b want 1", s, outp_div_zero); end
      consume();
    end
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_valid(lat);
    tests++; if (lat != 1) begin fails++; $display("FAIL ovf_latency got %0d want 1", lat); end
    tests++; if (outp_quot !== 32'h8000_0000) begin fails++; $display("FAIL ovf_quot got %h want 80000000", outp_quot); end
    tests++; if (outp_rem !== 32'd0) begin fails++; $display("FAIL ovf_rem got %h want 0", outp_rem); end
    tests++; if (outp_div_zero !== 1'b0) begin fails++; $display("FAIL ovf_dz got %0b want 0", outp_div_zero); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] q0, r0;
    logic dz0;
    ref_div(32'd123457, 32'd67, 1'b0, q0, r0, dz0);
    issue(32'd123457, 32'd67, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (outp_valid !== 1'b1 || inp_ready !== 1'b0 || outp_quot !== q0 || outp_rem !== r0 || outp_div_zero !== dz0) begin
        fails++;
        $display("FAIL backpressure_hold cyc=%0d got v=%0b rdy=%0b q=%h r=%h dz=%0b want v=1 rdy=0 q=%h r=%h dz=%0b",
                 i, outp_valid, inp_ready, outp_quot, outp_rem, outp_div_zero, q0, r0, dz0);
      end
    end
    consume();
    tests++; if (outp_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %0b want 0", outp_valid); end
    tests++; if (inp_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0b want 1", inp_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    issue(32'd77777, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tests++; if (outp_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %0b want 0", outp_valid); end
    tests++; if (inp_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %0b want 1", inp_ready); end
    tests++; if (outp_quot !== '0 || outp_rem !== '0 || outp_div_zero !== 1'b0) begin
      fails++; $display("FAIL midrst_results got q=%h r=%h dz=%0b want 0 0 0", outp_quot, outp_rem, outp_div_zero);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (outp_valid) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL midrst_discard valid cycles got %0d want 0", seen); end
    issue(32'd1000, 32'd10, 1'b0);
    wait_valid(lat);
    tests++; if (lat != 34) begin fails++; $display("FAIL post_rst_latency got %0d want 34", lat); end
    tests++; if (outp_quot !== 32'd100 || outp_rem !== 32'd0) begin
      fails++; $display("FAIL post_rst_result got q=%0d r=%0d want q=100 r=0", outp_quot, outp_rem);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, sel, done_cnt, exp_lat;
    logic [W-1:0] a, b, q, r;
    logic s, dz;
    done_cnt = 0;
    for (int n = 0; n < 1000; n++) begin
      sel = int'($urandom_range(0, 9));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = '1; s = 1'b1; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      ref_div(a, b, s, q, r, dz);
      exp_lat = (b == 0 || (s && a == 32'h8000_0000 && b == '1)) ? 1 : 34;
      issue(a, b, s);
      wait_valid(lat);
      if (outp_valid) done_cnt++;
      tests++;
      if (outp_quot !== q || outp_rem !== r || outp_div_zero !== dz || lat != exp_lat) begin
        fails++;
        $display("FAIL b2b op=%0d a=%h b=%h s=%0b got q=%h r=%h dz=%0b lat=%0d want q=%h r=%h dz=%0b lat=%0d",
                 n, a, b, s, outp_quot, outp_rem, outp_div_zero, lat, q, r, dz, exp_lat);
      end
      consume();
      tests++;
      if (outp_valid !== 1'b0 || inp_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_handshake op=%0d got v=%0b rdy=%0b want v=0 rdy=1", n, outp_valid, inp_ready);
      end
    end
    tests++; if (done_cnt != 1000) begin fails++; $display("FAIL b2b_count got %0d want 1000", done_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    inp_valid = 1'b0;
    inp_a = '0;
    inp_b = '0;
    inp_signed = 1'b0;
    outp_ready = 1'b0;
    test_reset();
    test_basic();
    test_special();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
